// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
//   state_t         : refill FSM state encoding (IDLE, REFILL)
//   off_w / idx_w   : word-offset and set-index widths
//   tag_w           : remaining tag width (32 - 2 - OFF_W - IDX_W)
//   way_w           : width of a way number (at least 1 bit)
package icache_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets, input int line_words);
        return 32 - 2 - $clog2(line_words) - $clog2(sets);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side bus of the instruction cache.
//   rdy, flush           : global enable and whole-cache invalidate
//   req_valid/req_addr   : fetch request from the fetcher
//   resp_hit/resp_inst   : combinational lookup result
//   busy                 : refill in progress
//   mem_req/mem_addr     : line-read request to the memory controller
//   mem_valid/mem_data   : refill beats, ascending word order
// slave = cache side, master = fetcher/memory side.
interface icache_if;
    logic        rdy;
    logic        flush;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        resp_hit;
    logic [31:0] resp_inst;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    modport slave (
        input  rdy, flush, req_valid, req_addr, mem_valid, mem_data,
        output resp_hit, resp_inst, busy, mem_req, mem_addr
    );

    modport master (
        output rdy, flush, req_valid, req_addr, mem_valid, mem_data,
        input  resp_hit, resp_inst, busy, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_way.sv
// One way of the cache: per-set tag, valid bit and LINE_WORDS data words.
//   rd_idx/rd_off -> rd_valid, rd_tag, rd_word : combinational lookup
//   wr_en, wr_idx, wr_off, wr_data             : registered refill word write
//   tag_we, wr_tag                             : registered tag write at wr_idx
//   valid_set (at wr_idx), valid_clr (at clr_idx), flush_all
module icache_way
    import icache_pkg::*;
#(
    parameter  int SETS       = 64,
    parameter  int LINE_WORDS = 4,
    localparam int IDX_W      = idx_w(SETS),
    localparam int OFF_W      = off_w(LINE_WORDS),
    localparam int TAG_W      = tag_w(SETS, LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_word,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             valid_set,
    input  logic             valid_clr,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             flush_all
);
    logic [31:0]      data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [SETS-1:0]  valid;

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_word  = data_mem[{rd_idx, rd_off}];

    // NOTE: data and tag arrays have no reset; the valid bits alone decide
    // whether their contents may ever be seen, so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en)  data_mem[{wr_idx, wr_off}] <= wr_data;
        if (tag_we) tag_mem[wr_idx]            <= wr_tag;
    end

    // Flush outranks the completion of a refill on the same edge.
    always_ff @(posedge clk) begin
        if (rst || flush_all) begin
            valid <= '0;
        end else begin
            if (valid_clr) valid[clr_idx] <= 1'b0;
            if (valid_set) valid[wr_idx]  <= 1'b1;
        end
    end
endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with on-chip line refill.
//   clk, rst : clock and synchronous active-high reset
//   bus      : icache_if.slave (fetch request/response, memory refill port)
// Lookup is combinational across all ways; a miss in IDLE starts a refill of
// the whole line into a victim way (first invalid, else per-set round-robin).
module icache_sa
    import icache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
);
    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(SETS, LINE_WORDS);
    localparam int WAY_W = way_w(WAYS);

    state_t             state, state_nxt;
    logic [OFF_W-1:0]   cnt;
    logic [31:0]        mem_addr_q;
    logic [WAY_W-1:0]   victim, victim_q;
    logic               abort;
    logic [WAY_W-1:0]   rr [SETS];

    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx, ref_idx;
    logic [TAG_W-1:0]   req_tag, ref_tag;
    logic [WAYS-1:0]    way_valid, match;
    logic [TAG_W-1:0]   way_tag  [WAYS];
    logic [31:0]        way_word [WAYS];
    logic               miss_start, beat, last_beat, flush_now;
    logic               unused_addr;

    assign req_off     = bus.req_addr[OFF_W+1:2];
    assign req_idx     = bus.req_addr[OFF_W+2 +: IDX_W];
    assign req_tag     = bus.req_addr[31 -: TAG_W];
    assign unused_addr = ^bus.req_addr[1:0];

    // The refill target is fully described by the latched line address.
    assign ref_idx = mem_addr_q[OFF_W+2 +: IDX_W];
    assign ref_tag = mem_addr_q[31 -: TAG_W];

    assign flush_now  = bus.flush && bus.rdy;
    assign miss_start = (state == ST_IDLE) && bus.req_valid && !bus.resp_hit
                        && bus.rdy && !bus.flush;
    assign beat       = (state == ST_REFILL) && bus.mem_valid && bus.rdy;
    assign last_beat  = beat && (cnt == OFF_W'(LINE_WORDS - 1));

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic sel;
        assign sel = (victim_q == WAY_W'(g));

        icache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_way (
            .clk       (clk),
            .rst       (rst),
            .rd_idx    (req_idx),
            .rd_off    (req_off),
            .rd_valid  (way_valid[g]),
            .rd_tag    (way_tag[g]),
            .rd_word   (way_word[g]),
            .wr_en     (beat && sel && !rst),
            .wr_idx    (ref_idx),
            .wr_off    (cnt),
            .wr_data   (bus.mem_data),
            .tag_we    (last_beat && sel && !rst),
            .wr_tag    (ref_tag),
            .valid_set (last_beat && sel && !abort),
            .valid_clr (miss_start && (victim == WAY_W'(g))),
            .clr_idx   (req_idx),
            .flush_all (flush_now)
        );

        assign match[g] = way_valid[g] && (way_tag[g] == req_tag);
    end

    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        bus.resp_inst = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (match[w]) bus.resp_inst = bus.resp_inst | way_word[w];
        end
    end
    assign bus.resp_hit = |match;

    // Victim: lowest-index invalid way, otherwise the set's RR pointer.
    always_comb begin
        logic found;
        found  = 1'b0;
        victim = rr[req_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !way_valid[w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (miss_start) state_nxt = ST_REFILL;
            ST_REFILL: if (last_beat)  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            mem_addr_q <= '0;
            victim_q   <= '0;
            abort      <= 1'b0;
        end else if (bus.rdy) begin
            if (miss_start) begin
                mem_addr_q <= {bus.req_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                victim_q   <= victim;
                cnt        <= '0;
                abort      <= 1'b0;
            end else if (state == ST_REFILL) begin
                if (beat)           cnt   <= cnt + 1'b1;
                if (last_beat)      abort <= 1'b0;
                else if (bus.flush) abort <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else if (last_beat) begin
            rr[ref_idx] <= (rr[ref_idx] == WAY_W'(WAYS - 1)) ? '0
                                                              : rr[ref_idx] + 1'b1;
        end
    end

    assign bus.busy     = (state == ST_REFILL);
    assign bus.mem_req  = (state == ST_REFILL);
    assign bus.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: directed scenarios followed by random
// traffic. A line-level reference model predicts every cycle's outputs; the
// predictions queue up and a monitor compares them against the DUT.
module tb_icache_sa;
    localparam int WAYS = 2;
    localparam int SETS = 64;
    localparam int LW   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_if bif();

    icache_sa #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        bit          hit;
        logic [31:0] inst;
        bit          busy;
        bit          mem_req;
        logic [31:0] mem_addr;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: each way/set holds a line number (addr / line bytes).
    bit          m_valid [WAYS][SETS];
    int unsigned m_line  [WAYS][SETS];
    logic [31:0] m_data  [WAYS][SETS][LW];
    int          m_ptr   [SETS];
    bit          m_busy  = 1'b0;
    logic [31:0] m_base  = '0;
    int          m_way   = 0;
    int          m_beat  = 0;
    bit          m_abort = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic void lookup(input logic [31:0] a, output bit h, output logic [31:0] d);
        int unsigned line = a / (LW * 4);
        int          set  = int'(line % SETS);
        int          word = int'((a / 4) % LW);
        h = 1'b0;
        d = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[w][set] && m_line[w][set] == line) begin
                h = 1'b1;
                d = m_data[w][set][word];
            end
        end
    endfunction

    function automatic void clear_valid();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
    endfunction

    // One clock cycle: drive inputs, predict outputs, advance the model.
    task automatic step(input bit r, input bit rd, input bit fl, input bit rv,
                        input logic [31:0] a, input bit mv, input logic [31:0] md);
        exp_t        e;
        bit          h;
        logic [31:0] d;
        bit          was_busy;
        rst           = r;
        bif.rdy       = rd;
        bif.flush     = fl;
        bif.req_valid = rv;
        bif.req_addr  = a;
        bif.mem_valid = mv;
        bif.mem_data  = md;

        lookup(a, h, d);
        e.hit      = h;
        e.inst     = d;
        e.busy     = m_busy;
        e.mem_req  = m_busy;
        e.mem_addr = m_base;
        sb_q.push_back(e);

        if (r) begin
            clear_valid();
            for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
            m_busy  = 1'b0;
            m_base  = '0;
            m_beat  = 0;
            m_abort = 1'b0;
        end else if (rd) begin
            was_busy = m_busy;
            if (was_busy && mv) begin
                int unsigned line = m_base / (LW * 4);
                int          set  = int'(line % SETS);
                m_data[m_way][set][m_beat] = md;
                if (m_beat == LW - 1) begin
                    m_line[m_way][set]  = line;
                    m_valid[m_way][set] = !m_abort;
                    m_ptr[set]          = (m_ptr[set] + 1) % WAYS;
                    m_busy              = 1'b0;
                    m_abort             = 1'b0;
                end else begin
                    m_beat++;
                end
            end
            if (!was_busy && rv && !h && !fl) begin
                int set = int'((a / (LW * 4)) % SETS);
                int v   = m_ptr[set];
                for (int w = WAYS - 1; w >= 0; w--)
                    if (!m_valid[w][set]) v = w;
                m_valid[v][set] = 1'b0;
                m_way   = v;
                m_base  = a & ~32'(LW * 4 - 1);
                m_beat  = 0;
                m_abort = 1'b0;
                m_busy  = 1'b1;
            end
            if (fl) begin
                clear_valid();
                if (m_busy) m_abort = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic probe(input logic [31:0] a);
        step(0, 1, 0, 0, a, 0, '0);
    endtask

    task automatic req(input logic [31:0] a);
        step(0, 1, 0, 1, a, 0, '0);
    endtask

    task automatic beat(input logic [31:0] md);
        step(0, 1, 0, 0, '0, 1, md);
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] seed);
        req(a);
        for (int i = 0; i < LW; i++) beat(seed * (i + 1));
    endtask

    // Monitor: outputs settle after the negedge drive; compare 2 time units later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("resp_hit",  32'(bif.resp_hit), 32'(e.hit));
                check("resp_inst", bif.resp_inst,     e.inst);
                check("busy",      32'(bif.busy),     32'(e.busy));
                check("mem_req",   32'(bif.mem_req),  32'(e.mem_req));
                check("mem_addr",  bif.mem_addr,      e.mem_addr);
            end
        end
    end

    initial begin
        int drain;
        rst           = 1'b1;
        bif.rdy       = 1'b1;
        bif.flush     = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_addr  = '0;
        bif.mem_valid = 1'b0;
        bif.mem_data  = '0;
        clear_valid();
        for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
        repeat (2) @(negedge clk);

        // Cold miss, then the refilled words hit.
        req(32'h1008);
        probe(32'h0);
        beat(32'h11); beat(32'h22); beat(32'h33); beat(32'h44);
        probe(32'h1008);
        probe(32'h100C);

        // Conflict and eviction in set 0.
        fill(32'h2000, 32'h21);
        probe(32'h1000); probe(32'h2000);
        fill(32'h3000, 32'h31);
        probe(32'h1000); probe(32'h2004); probe(32'h300C);

        // Flush in the middle of a refill.
        fill(32'h1000, 32'h12);
        req(32'h4000);
        beat(32'h41); beat(32'h42);
        step(0, 1, 1, 0, '0, 0, '0);
        beat(32'h43); beat(32'h44);
        probe(32'h4000); probe(32'h1000);

        // rdy stall while beats are offered.
        req(32'h6000);
        beat(32'h61);
        repeat (3) step(0, 0, 0, 0, '0, 1, 32'hDEAD_BEEF);
        beat(32'h62); beat(32'h63); beat(32'h64);
        probe(32'h6004); probe(32'h600C);

        // Reset mid-refill.
        req(32'h5000);
        beat(32'h51); beat(32'h52);
        step(1, 1, 0, 0, '0, 0, '0);
        probe(32'h5000); probe(32'h6004); probe(32'h3000);

        // Hit under refill.
        fill(32'h2000, 32'h25);
        req(32'h5000);
        beat(32'h55);
        step(0, 1, 0, 1, 32'h2004, 1, 32'hAA);
        beat(32'h57); beat(32'h58);
        probe(32'h5008); probe(32'h2004);

        // Random traffic over a small pool of conflicting lines.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            bit          r, rd, fl, rv, mv;
            a  = 32'h0001_0000 | ($urandom_range(0, 3) << 10)
                 | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
            r  = ($urandom_range(0, 999) < 2);
            rd = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 99) < 2);
            rv = ($urandom_range(0, 1) == 1);
            mv = m_busy ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
            step(r, rd, fl, rv, a, mv, $urandom);
        end

        drain = 0;
        while (sb_q.size() > 0 && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        #3;
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
